// File: rtl/wb_cmd_master_pkg.sv
// Shared Wishbone widths and master FSM encoding, also used by the slave-side decoder.
package wb_cmd_master_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_ADR_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_e;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command/response stream plus Wishbone initiator signals of wb_cmd_master.
interface wb_cmd_master_if;
  import wb_cmd_master_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_we;
  logic [WB_SEL_W-1:0] cmd_sel;
  logic [WB_ADR_W-1:0] cmd_adr;
  logic [WB_DAT_W-1:0] cmd_dat;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [WB_DAT_W-1:0] rsp_dat;
  logic                rsp_timeout;
  logic                busy;

  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic                wbm_we_o;
  logic [WB_SEL_W-1:0] wbm_sel_o;
  logic [WB_ADR_W-1:0] wbm_adr_o;
  logic [WB_DAT_W-1:0] wbm_dat_o;
  logic                wbm_ack_i;
  logic [WB_DAT_W-1:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready, wbm_ack_i, wbm_dat_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_timeout, busy,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready, wbm_ack_i, wbm_dat_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_timeout, busy,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one single-transfer cycle per command, with
// ACK timeout and a held response until consumed.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_cmd_master_if.master        bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wbm_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      we_q          <= 1'b0;
      sel_q         <= '0;
      adr_q         <= '0;
      dat_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_dat_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      cyc_q         <= cyc_d;
      stb_q         <= stb_d;
      we_q          <= we_d;
      sel_q         <= sel_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_dat_q     <= rsp_dat_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    busy_d        = busy_q;
    cyc_d         = cyc_q;
    stb_d         = stb_q;
    we_d          = we_q;
    sel_d         = sel_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_dat_d     = rsp_dat_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          we_d        = bus.cmd_we;
          sel_d       = bus.cmd_sel;
          adr_d       = bus.cmd_adr;
          dat_d       = bus.cmd_dat;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = BUS;
        end
      end
      BUS: begin
        // ACK takes priority over the terminal count on the same edge.
        if (bus.wbm_ack_i) begin
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          rsp_dat_d     = we_q ? '0 : bus.wbm_dat_i;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          rsp_dat_d     = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_dat     = rsp_dat_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.wbm_cyc_o   = cyc_q;
  assign bus.wbm_stb_o   = stb_q;
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_sel_o   = sel_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with an expected-response scoreboard.
module tb_wb_cmd_master;
  import wb_cmd_master_pkg::*;

  localparam int TIMEOUT = 16;

  typedef struct {
    logic [31:0] dat;
    logic        to;
  } exp_t;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  wb_cmd_master_if bus();

  wb_cmd_master #(.TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full command/response transaction; wait_n < 0 means the slave never ACKs.
  task automatic do_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input int wait_n, input logic [31:0] rdata,
                         input int rsp_delay, input bit hold_valid, input bit ack_in_resp);
    exp_t e;
    exp_t got;
    int   n;
    bit   to;
    to    = (wait_n < 0) || (wait_n >= TIMEOUT);
    e.to  = to;
    e.dat = (to || we) ? 32'h0 : rdata;
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_sel   = sel;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    sb.push_back(e);
    step();
    if (!hold_valid) bus.cmd_valid = 1'b0;
    bus.cmd_we    = ~we;
    bus.cmd_sel   = ~sel;
    bus.cmd_adr   = $urandom;
    bus.cmd_dat   = $urandom;
    bus.wbm_dat_i = rdata;
    n = 0;
    while (bus.wbm_stb_o === 1'b1 && n < TIMEOUT + 4) begin
      n++;
      chk("bus_cyc", 32'(bus.wbm_cyc_o), 32'd1);
      chk("bus_we", 32'(bus.wbm_we_o), 32'(we));
      chk("bus_sel", 32'(bus.wbm_sel_o), 32'(sel));
      chk("bus_adr", bus.wbm_adr_o, adr);
      chk("bus_dat", bus.wbm_dat_o, dat);
      chk("cmd_ready_bus", 32'(bus.cmd_ready), 32'd0);
      chk("rsp_valid_bus", 32'(bus.rsp_valid), 32'd0);
      bus.wbm_ack_i = (n == wait_n + 1);
      step();
      bus.wbm_ack_i = 1'b0;
    end
    chk("stb_cycles", 32'(n), to ? 32'(TIMEOUT) : 32'(wait_n + 1));
    chk("cyc_dropped", 32'(bus.wbm_cyc_o), 32'd0);
    chk("stb_dropped", 32'(bus.wbm_stb_o), 32'd0);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.wbm_dat_i = $urandom;
    for (int i = 0; i < rsp_delay; i++) begin
      bus.wbm_ack_i = ack_in_resp && (i % 2 == 0);
      step();
      bus.wbm_ack_i = 1'b0;
      chk("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_hold_dat", bus.rsp_dat, e.dat);
      chk("rsp_hold_to", 32'(bus.rsp_timeout), 32'(e.to));
      chk("rsp_hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rsp_hold_busy", 32'(bus.busy), 32'd1);
      chk("rsp_hold_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      chk("rsp_dat", bus.rsp_dat, got.dat);
      chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(got.to));
    end
    step();
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_done", 32'(bus.rsp_valid), 32'd0);
    chk("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    chk("busy_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i      = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_sel   = 4'h0;
    bus.cmd_adr   = 32'h0;
    bus.cmd_dat   = 32'h0;
    bus.rsp_ready = 1'b0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    repeat (3) step();
    chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    chk("rst_we", 32'(bus.wbm_we_o), 32'd0);
    chk("rst_sel", 32'(bus.wbm_sel_o), 32'd0);
    chk("rst_adr", bus.wbm_adr_o, 32'd0);
    chk("rst_dat_o", bus.wbm_dat_o, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_dat", bus.rsp_dat, 32'd0);
    chk("rst_rsp_to", 32'(bus.rsp_timeout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    wb_rst_i = 1'b0;
    step();
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Zero-wait write, then a read with three wait states.
    do_xfer(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_0001, 0, 32'h0, 0, 1'b0, 1'b0);
    do_xfer(1'b0, 4'hF, 32'h3000_0010, 32'h0, 3, 32'h1234_5678, 0, 1'b0, 1'b0);

    // Timeout without ACK, ACK on the terminal cycle, and a write timeout.
    do_xfer(1'b0, 4'h3, 32'h3000_0020, 32'h0, -1, 32'h5555_AAAA, 0, 1'b0, 1'b0);
    do_xfer(1'b0, 4'hF, 32'h3000_0024, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
    do_xfer(1'b1, 4'hC, 32'h3000_0028, 32'h1111_2222, -1, 32'h0, 0, 1'b0, 1'b0);

    // Response backpressure, with and without ACK glitches in RESP.
    do_xfer(1'b0, 4'h1, 32'h3000_0030, 32'h0, 1, 32'hDEAD_BEEF, 5, 1'b0, 1'b0);
    do_xfer(1'b1, 4'h6, 32'h3000_0034, 32'h7777_8888, 2, 32'h0, 4, 1'b0, 1'b1);

    // Reset during the second STB cycle of a slow read drops the transfer.
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_sel   = 4'hF;
    bus.cmd_adr   = 32'h3000_0040;
    step();
    bus.cmd_valid = 1'b0;
    chk("mid_stb_c1", 32'(bus.wbm_stb_o), 32'd1);
    step();
    chk("mid_stb_c2", 32'(bus.wbm_stb_o), 32'd1);
    wb_rst_i = 1'b1;
    step();
    chk("mid_rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("mid_rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    wb_rst_i = 1'b0;
    step();
    do_xfer(1'b0, 4'hF, 32'h3000_0044, 32'h0, 2, 32'h0BAD_F00D, 1, 1'b0, 1'b0);

    // Spurious ACK while idle.
    bus.wbm_ack_i = 1'b1;
    step();
    bus.wbm_ack_i = 1'b0;
    step();
    chk("idle_ack_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("idle_ack_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("idle_ack_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("idle_ack_busy", 32'(bus.busy), 32'd0);

    // Back-to-back commands with cmd_valid held high throughout.
    do_xfer(1'b1, 4'hF, 32'h3000_0050, 32'hABCD_0001, 0, 32'h0, 2, 1'b1, 1'b0);
    do_xfer(1'b0, 4'hF, 32'h3000_0054, 32'h0, 1, 32'h600D_CAFE, 0, 1'b1, 1'b0);
    bus.cmd_valid = 1'b0;
    step();
    chk("b2b_no_extra_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("b2b_idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Wishbone classic initiator: the requester end of the user-area Wishbone slave bus. It converts a valid/ready command stream (single read or write) into one Wishbone single-transfer cycle and returns data or a timeout status on a valid/ready response stream. It sits inside the user project, so on-chip sources (LA-driven test logic, IO-driven loaders) can reach Wishbone-mapped cell-array registers without the management SoC.

Parameters:
TIMEOUT, 16, maximum number of cycles STB stays asserted without ACK before abort; legal range 1..65535
CNT_W, $clog2(TIMEOUT+1), timeout counter width; derived, do not override

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_we  in  1  1=write, 0=read
cmd_sel  in  4  byte selects
cmd_adr  in  32  byte address
cmd_dat  in  32  write data
rsp_valid  out  1  response offered
rsp_ready  in  1  response consumed when valid&ready
rsp_dat  out  32  read data; 0 for writes and timeouts
rsp_timeout  out  1  1 = transfer aborted, no ACK
busy  out  1  high whenever not IDLE
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte selects
wbm_adr_o  out  32  address
wbm_dat_o  out  32  write data
wbm_ack_i  in  1  slave acknowledge
wbm_dat_i  in  32  slave read data

Behaviour:
- All outputs registered. Reset values: cyc/stb/we=0, sel=0, adr=0, dat_o=0, rsp_valid=0, rsp_dat=0, rsp_timeout=0, busy=0; cmd_ready=1 in the cycle after reset releases (IDLE).
- FSM states: IDLE, BUS, RESP.
- IDLE: cmd_ready=1. On valid&ready at edge N: latch we/sel/adr/dat onto wbm_* outputs, set cyc=stb=1, clear the counter, go BUS. Bus signals are visible after edge N.
- BUS: cmd_ready=0. cyc, stb, adr, sel, we, and dat_o are held stable.
  - ACK sampled high at an edge: drop cyc/stb; rsp_dat = wbm_dat_i for reads, 0 for writes; rsp_timeout=0; rsp_valid=1; go RESP.
  - No ACK and counter==TIMEOUT-1: drop cyc/stb; rsp_dat=0; rsp_timeout=1; rsp_valid=1; go RESP.
  - Otherwise the counter increments.
  - STB is therefore high for at most TIMEOUT cycles.
  - ACK on the same edge as the terminal count: ACK wins, normal completion.
- RESP: rsp_valid, rsp_dat, and rsp_timeout are held until rsp_ready. On valid&ready: rsp_valid=0, go IDLE. cmd_ready returns to 1 in the following cycle; there is no command/response overlap.
- Latency with a zero-wait slave (ACK in the first STB cycle): command accepted at edge N, ACK sampled at edge N+1, rsp_valid high after N+1. Each wait state adds 1 cycle.
- wbm_ack_i outside BUS is ignored, with no state change.
- wbm_we_o, wbm_sel_o, wbm_adr_o, and wbm_dat_o keep their last values after the cycle ends. They are don't-care while cyc=0 and must not be checked then.
- Reset asserted mid-transfer: at the next edge cyc/stb=0, rsp_valid=0, FSM=IDLE. The in-flight command is lost with no response.
- cmd_* inputs are ignored while cmd_ready=0.

Decomposition:
- The shared package holds the FSM state encoding (IDLE=2'd0, BUS=2'd1, RESP=2'd2) and the WB_DAT_W=32, WB_ADR_W=32, and WB_SEL_W=4 constants. These are reused by the slave-side decoder.
- No sub-module is required. An optional small wb_timeout_cnt (clear/enable/terminal-count) is acceptable if it is reused elsewhere.

Test Plan:
1. Write, zero-wait slave: cmd adr=0x3000_0004, dat=0xA5A5_0001, sel=4'hF, we=1 → one STB cycle with these values; rsp_valid at the next cycle; rsp_dat=0; rsp_timeout=0.
2. Read, 3 wait states, slave returns 0x1234_5678 → STB high exactly 4 cycles; rsp_dat=0x1234_5678; bus outputs stable throughout.
3. Timeout, TIMEOUT=16, slave never ACKs → STB high exactly 16 cycles, then rsp_timeout=1 and rsp_dat=0. With ACK on cycle 16 instead → normal completion, rsp_timeout=0.
4. Response backpressure: rsp_ready low for 5 cycles → rsp fields held constant; cmd_ready stays 0; IDLE only after the handshake.
5. Reset mid-BUS (cycle 2 of a 10-wait read) → cyc/stb=0 and rsp_valid=0 at the next edge; a fresh command afterwards completes normally.
6. Spurious ACK pulses in IDLE and RESP → no state or output change; back-to-back commands with cmd_valid held high → one transfer per response handshake.
